// File: rtl/train_stop_sequencer.sv
// Station-stop sequencer: run, brake, door dwell, door close, idle; emergency overrides all.
// Moore FSM with every output registered and decoded from the next-state value.
module train_stop_sequencer #(
   parameter logic [12:0] BRAKE_T = 13'd100,
   parameter logic [12:0] DWELL_T = 13'd500,
   parameter logic [12:0] CLOSE_T = 13'd50
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go_i,
   input  logic        at_station_i,
   input  logic        door_clear_i,
   input  logic        emergency_i,
   input  logic        timer_done_i,
   output logic [12:0] timer_t_o,
   output logic        timer_load_o,
   output logic        motor_en_o,
   output logic        brake_o,
   output logic        door_open_o,
   output logic [2:0]  state_o,
   output logic [3:0]  reopen_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_BRAKE = 3'd2,
      S_OPEN  = 3'd3,
      S_CLOSE = 3'd4,
      S_ESTOP = 3'd5
   } state_e;

   state_e      state_q, state_d;
   logic        at_q;
   logic        load_q, load_d;
   logic        post_q;
   logic [12:0] timer_t_q, timer_t_d;
   logic        motor_q, motor_d;
   logic        brake_q, brake_d;
   logic        door_q, door_d;
   logic [3:0]  reopen_q, reopen_d;
   logic        expired;
   logic        at_rise;
   logic        timed_d;

   // The timer still shows its previous expiry during the load cycle and the one after.
   assign expired = timer_done_i & ~load_q & ~post_q;
   assign at_rise = at_station_i & ~at_q;

   always_comb begin
      state_d  = state_q;
      reopen_d = reopen_q;
      if (emergency_i) begin
         state_d = S_ESTOP;
      end else begin
         case (state_q)
            S_ESTOP: state_d = S_IDLE;
            S_IDLE:  if (go_i) state_d = S_RUN;
            S_RUN:   if (at_rise) state_d = S_BRAKE;
            S_BRAKE: if (expired) state_d = S_OPEN;
            S_OPEN:  if (expired) state_d = S_CLOSE;
            S_CLOSE: begin
               if (!door_clear_i) begin
                  state_d = S_OPEN;
                  if (reopen_q != 4'd15) reopen_d = reopen_q + 4'd1;
               end else if (expired) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      if (state_d == S_RUN && state_q != S_RUN) reopen_d = '0;
   end

   always_comb begin
      motor_d   = 1'b0;
      brake_d   = 1'b1;
      door_d    = 1'b0;
      timer_t_d = '0;
      timed_d   = 1'b0;
      case (state_d)
         S_RUN: begin
            motor_d = 1'b1;
            brake_d = 1'b0;
         end
         S_BRAKE: begin
            timer_t_d = BRAKE_T;
            timed_d   = 1'b1;
         end
         S_OPEN: begin
            timer_t_d = DWELL_T;
            door_d    = 1'b1;
            timed_d   = 1'b1;
         end
         S_CLOSE: begin
            timer_t_d = CLOSE_T;
            timed_d   = 1'b1;
         end
         default: ;
      endcase
      load_d = timed_d && (state_d != state_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         at_q      <= 1'b1;
         load_q    <= 1'b0;
         post_q    <= 1'b0;
         timer_t_q <= '0;
         motor_q   <= 1'b0;
         brake_q   <= 1'b1;
         door_q    <= 1'b0;
         reopen_q  <= '0;
      end else begin
         state_q   <= state_d;
         at_q      <= at_station_i;
         load_q    <= load_d;
         post_q    <= load_q;
         timer_t_q <= timer_t_d;
         motor_q   <= motor_d;
         brake_q   <= brake_d;
         door_q    <= door_d;
         reopen_q  <= reopen_d;
      end
   end

   assign state_o      = state_q;
   assign timer_t_o    = timer_t_q;
   assign timer_load_o = load_q;
   assign motor_en_o   = motor_q;
   assign brake_o      = brake_q;
   assign door_open_o  = door_q;
   assign reopen_cnt_o = reopen_q;

endmodule

// File: doc/train_stop_sequencer.md
# train_stop_sequencer

Moore state machine that sequences one station stop for the train controller: run, brake, door-open dwell, door close, then idle until relaunched. It sits directly upstream of the countdown timer. It drives the timer's 13-bit duration and a one-cycle load strobe, and consumes the timer's `timer` (expired) flag to leave each timed phase. An emergency input overrides every state.

## Interface
- `BRAKE_T`, 13'd100, braking phase duration loaded into the timer
- `DWELL_T`, 13'd500, door-open dwell duration loaded into the timer
- `CLOSE_T`, 13'd50, door-closing duration loaded into the timer
- `clk`  in  1  system clock; all registers update on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `go`  in  1  launch request; level-sensitive
- `at_station`  in  1  station sensor; only its rising edge is used
- `door_clear`  in  1  1 = doorway unobstructed
- `emergency`  in  1  1 = emergency stop; level-sensitive, highest priority
- `timer_done`  in  1  timer expired flag (timer `timer` output)
- `timer_t`  out  13  duration presented to the timer
- `timer_load`  out  1  one-cycle strobe: timer samples `timer_t`
- `motor_en`  out  1  traction enable
- `brake`  out  1  brake applied
- `door_open`  out  1  door actuator open command
- `state`  out  3  current state code
- `reopen_cnt`  out  4  door reopen events this stop; saturates at 15

## Operation
- State codes: IDLE=0, RUN=1, BRAKE=2, OPEN=3, CLOSE=4, ESTOP=5. Codes 6 and 7 return to IDLE on the next clock.
- Outputs per state:
  - IDLE: brake=1.
  - RUN: motor_en=1, brake=0.
  - BRAKE: brake=1.
  - OPEN: brake=1, door_open=1.
  - CLOSE: brake=1, door_open=0.
  - ESTOP: brake=1, motor_en=0, door_open=0.
- Transitions, in priority order:
  - `emergency`=1: any state -> ESTOP.
  - ESTOP: `emergency`=0 -> IDLE.
  - IDLE: `go`=1 -> RUN.
  - RUN: `at_station` rising edge -> BRAKE. The edge is detected against a registered copy of `at_station`. The registered copy resets to 1, so a sensor held high through reset produces no edge.
  - BRAKE: expiry -> OPEN.
  - OPEN: expiry -> CLOSE.
  - CLOSE: `door_clear`=0 -> OPEN and `reopen_cnt` increments, saturating at 15. Otherwise expiry -> IDLE.
- Expiry means `timer_done`=1 sampled while the blanking window is not active.
- Timer loading: on entry to BRAKE, OPEN or CLOSE, `timer_load`=1 for exactly the first cycle in the state. `timer_t` carries BRAKE_T, DWELL_T or CLOSE_T respectively. Re-entry into OPEN from CLOSE reloads DWELL_T.
- Outside timed states, `timer_t`=0 and `timer_load`=0.
- Blanking: `timer_done` is ignored in the load cycle and the cycle after it. This masks the stale expired flag held by the timer before it reloads.
- `reopen_cnt` clears on entry to RUN.
- Duration widths match the timer's 13-bit input; there is no arithmetic on durations inside this block.

## Timing
- Reset (asynchronous, `rst_n`=0): state=IDLE, brake=1, motor_en=0, door_open=0, timer_load=0, timer_t=0, reopen_cnt=0, blanking cleared, registered `at_station`=1.
- All outputs are registered, decoded from the next-state value. Each output changes on the same clock edge as `state`.
- Input-to-output latency is 1 cycle: an input sampled at edge N sets `state` and the outputs after edge N.
- Minimum residency in a timed state is 3 cycles: load cycle, blank cycle, then the first qualifying `timer_done`.
- Simultaneous events:
  - `emergency` beats every other condition.
  - In CLOSE, `door_clear`=0 beats expiry.
  - In RUN, a `go` drop has no effect. RUN exits only on an `at_station` edge or `emergency`.
- ESTOP entered mid-phase abandons the timer with no load strobe. After `emergency` drops, the stop restarts from IDLE.
- Reset deassertion mid-stop restarts from IDLE with the reset values above.

## Test plan
- Reset with `at_station`=1 held, then `go`=1 -> RUN after 1 cycle, and no BRAKE entry while `at_station` stays high.
- Full stop: `go`=1, at_station 0->1, timer model with 3-cycle expiry -> states 1,2,3,4,0. Load strobes carry 100, 500 and 50, each exactly 1 cycle wide.
- Stale flag: `timer_done` held 1 throughout -> each timed state lasts exactly 3 cycles.
- Obstruction: `door_clear`=0 for 1 cycle in CLOSE -> OPEN, DWELL_T reloaded, `reopen_cnt`=1. Sixteen obstructions -> `reopen_cnt` stays 15. `reopen_cnt` reads 0 after the next RUN entry.
- `emergency` pulse in OPEN -> ESTOP next cycle with door_open=0 and brake=1. After `emergency` drops -> IDLE 1 cycle later.
- `rst_n` low asynchronously during BRAKE -> outputs reach reset values without a clock edge.
